mem_arbiter_ctrl: RTL and testbench

- Single owner of the byte-wide unified RAM port.
- Arbitrates between the instruction-fetch requester (fetch stage / icache refill) and the load/store unit.
- Sequences each 1/2/4-byte access as consecutive byte transfers, assembles read data little-endian, and returns a one-cycle done pulse to the winning requester.
- Supports abort of an in-flight fetch on branch/jump redirect.

---
 rtl/mem_arbiter_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: sole owner of the byte-wide unified RAM port.
// Arbitrates instruction fetch (IF) against the load/store unit (MEM),
// splits each 1/2/4-byte access into consecutive byte transfers,
// assembles read data little-endian and returns a one-cycle done pulse.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level) and word address
//   if_abort              cancel pending/in-flight fetch
//   if_done/if_inst       fetch done pulse and fetched word
//   mem_req/mem_we        load/store request (level), 1 = store
//   mem_len               00 byte, 01 half, 10/11 word
//   mem_addr/mem_wdata    data address, store data (low bytes used)
//   mem_done/mem_rdata    done pulse, zero-extended load data
//   ram_addr/ram_we       RAM byte address, write enable
//   ram_wdata/ram_rdata   RAM write byte, registered read byte
module mem_arbiter_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;        // edges since accept (accept edge = 0)
  logic [2:0]        nbytes, nbytes_n;
  logic [3:0]        starve, starve_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [31:0]       wbuf, wbuf_n;
  logic [31:0]       rbuf, rbuf_n;
  logic              if_done_n, mem_done_n, ram_we_n;
  logic [31:0]       if_inst_n, mem_rdata_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [7:0]        ram_wdata_n;

  logic              if_elig, mem_elig;
  logic [2:0]        mem_nbytes;
  logic [1:0]        cap_idx;
  logic [31:0]       rbuf_merged;

  always_comb begin
    if_elig  = if_req && !if_done && !if_abort;
    mem_elig = mem_req && !mem_done;
    case (mem_len)
      2'b00:   mem_nbytes = 3'd1;
      2'b01:   mem_nbytes = 3'd2;
      default: mem_nbytes = 3'd4;
    endcase
    // Byte presented at edge k arrives in time for edge k+2.
    cap_idx     = cnt[1:0] - 2'd2;
    rbuf_merged = rbuf;
    rbuf_merged[8*cap_idx +: 8] = ram_rdata;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    nbytes_n    = nbytes;
    starve_n    = starve;
    base_n      = base;
    wbuf_n      = wbuf;
    rbuf_n      = rbuf;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    ram_we_n    = 1'b0;
    if_inst_n   = if_inst;
    mem_rdata_n = mem_rdata;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;

    case (state)
      IDLE: begin
        if (mem_elig && !(if_elig && starve == 4'(STARVE_LIMIT))) begin
          if (if_elig && starve != 4'hF) starve_n = starve + 4'd1;
          base_n     = mem_addr;
          nbytes_n   = mem_nbytes;
          cnt_n      = 3'd1;
          ram_addr_n = mem_addr;
          if (mem_we) begin
            state_n     = MEM_WR;
            wbuf_n      = mem_wdata;
            ram_we_n    = 1'b1;
            ram_wdata_n = mem_wdata[7:0];
          end else begin
            state_n = MEM_RD;
            rbuf_n  = '0;
          end
        end else if (if_elig) begin
          starve_n   = '0;
          base_n     = if_addr;
          nbytes_n   = 3'd4;
          cnt_n      = 3'd1;
          ram_addr_n = if_addr;
          state_n    = IF_RD;
          rbuf_n     = '0;
        end
      end

      IF_RD, MEM_RD: begin
        if (state == IF_RD && if_abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          if (cnt < nbytes) ram_addr_n = base + ADDR_W'(cnt);
          if (cnt >= 3'd2)  rbuf_n = rbuf_merged;
          if (cnt == nbytes + 3'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == IF_RD) begin
              if_done_n = 1'b1;
              if_inst_n = rbuf_merged;
            end else begin
              mem_done_n  = 1'b1;
              mem_rdata_n = rbuf_merged;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      MEM_WR: begin
        if (cnt < nbytes) begin
          ram_addr_n  = base + ADDR_W'(cnt);
          ram_we_n    = 1'b1;
          ram_wdata_n = wbuf[8*cnt[1:0] +: 8];
          cnt_n       = cnt + 3'd1;
        end else begin
          mem_done_n = 1'b1;
          state_n    = IDLE;
          cnt_n      = '0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      starve    <= '0;
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_we    <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      nbytes    <= nbytes_n;
      starve    <= starve_n;
      base      <= base_n;
      wbuf      <= wbuf_n;
      rbuf      <= rbuf_n;
      if_done   <= if_done_n;
      mem_done  <= mem_done_n;
      ram_we    <= ram_we_n;
      if_inst   <= if_inst_n;
      mem_rdata <= mem_rdata_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed testbench for mem_arbiter_ctrl with a 1 KiB registered-read
// byte RAM model (address bits [9:0]).
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  logic [7:0]  ram [1024] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_if_done  = 0;
  int n_mem_done = 0;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr[9:0]];
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
    if (if_done)  n_if_done  <= n_if_done + 1;
    if (mem_done) n_mem_done <= n_mem_done + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  // Latency counts ticks from the accept edge (tick 1) to the done edge.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = len; mem_addr = a;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      tick;
      if (mem_done) lat = c;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, mem_rdata, exp);
    mem_req = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    int seq [6];
    int k, mcnt, done_before, if_done_before;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;

    preload(10'h100, 8'h13); preload(10'h101, 8'h05);
    preload(10'h102, 8'h10); preload(10'h103, 8'h00);
    preload(10'h200, 8'hAB); preload(10'h201, 8'hCD);
    preload(10'h300, 8'h11); preload(10'h301, 8'h22);
    preload(10'h302, 8'h33); preload(10'h303, 8'h44);
    preload(10'h3FF, 8'h5A); preload(10'h000, 8'hA5);
    tick;

    check_eq("rst_ram_addr",  ram_addr, 32'h0);
    check_eq("rst_ram_we",    32'(ram_we), 32'h0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    check_eq("rst_if_done",   32'(if_done), 32'h0);
    check_eq("rst_mem_done",  32'(mem_done), 32'h0);
    check_eq("rst_if_inst",   if_inst, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick;

    // Word fetch
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("fetch_addr", ram_addr, 32'h100 + 32'(i));
      check_eq("fetch_early_done", 32'(if_done), 32'h0);
    end
    tick;
    check_eq("fetch_e4_done", 32'(if_done), 32'h0);
    tick;
    check_eq("fetch_done", 32'(if_done), 32'h1);
    check_eq("fetch_inst", if_inst, 32'h00100513);
    if_req = 1'b0;
    tick;
    check_eq("fetch_done_pulse", 32'(if_done), 32'h0);
    check_eq("fetch_addr_hold", ram_addr, 32'h103);

    // Contention: MEM wins, IF accepted on the edge mem_done falls
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h200;
    tick;
    check_eq("cont_mem_first", ram_addr, 32'h200);
    tick;
    check_eq("cont_mem_b1", ram_addr, 32'h201);
    tick;
    check_eq("cont_mem_e2_done", 32'(mem_done), 32'h0);
    tick;
    check_eq("cont_mem_done", 32'(mem_done), 32'h1);
    check_eq("cont_mem_rdata", mem_rdata, 32'h0000CDAB);
    mem_req = 1'b0;
    tick;
    check_eq("cont_mem_done_pulse", 32'(mem_done), 32'h0);
    check_eq("cont_if_accept", ram_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("cont_if_early_done", 32'(if_done), 32'h0);
    end
    tick;
    check_eq("cont_if_done", 32'(if_done), 32'h1);
    check_eq("cont_if_inst", if_inst, 32'h00100513);
    if_req = 1'b0;
    tick;

    // Byte store
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h20; mem_wdata = 32'h123456EF;
    tick;
    check_eq("bst_we",    32'(ram_we), 32'h1);
    check_eq("bst_addr",  ram_addr, 32'h20);
    check_eq("bst_wdata", 32'(ram_wdata), 32'hEF);
    check_eq("bst_e0_done", 32'(mem_done), 32'h0);
    tick;
    check_eq("bst_e1_we",   32'(ram_we), 32'h0);
    check_eq("bst_e1_done", 32'(mem_done), 32'h1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    check_eq("bst_done_pulse", 32'(mem_done), 32'h0);
    check_eq("bst_ram20", 32'(ram[10'h020]), 32'hEF);
    check_eq("bst_ram21", 32'(ram[10'h021]), 32'h00);

    // Word store
    wd = 32'hDEADBEEF;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("wst_we",    32'(ram_we), 32'h1);
      check_eq("wst_addr",  ram_addr, 32'h40 + 32'(i));
      check_eq("wst_wdata", 32'(ram_wdata), 32'(wd[8*i +: 8]));
      check_eq("wst_early_done", 32'(mem_done), 32'h0);
    end
    tick;
    check_eq("wst_e4_we",   32'(ram_we), 32'h0);
    check_eq("wst_e4_done", 32'(mem_done), 32'h1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;

    // Loads of various lengths, including len=11 and address wrap
    do_load("ld_word", 32'h40, 2'b10, 32'hDEADBEEF, 6);
    do_load("ld_len3", 32'h40, 2'b11, 32'hDEADBEEF, 6);
    do_load("ld_byte", 32'h41, 2'b00, 32'h000000BE, 3);
    do_load("ld_half_wrap", 32'hFFFFFFFF, 2'b01, 32'h0000A55A, 4);

    // Abort at cycle 2 of a fetch with a load waiting
    if_done_before = n_if_done;
    if_req = 1'b1; if_addr = 32'h300;
    tick;
    check_eq("abt_e0_addr", ram_addr, 32'h300);
    tick;
    if_abort = 1'b1; if_req = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20;
    tick;
    if_abort = 1'b0;
    check_eq("abt_addr_hold", ram_addr, 32'h301);
    tick;
    check_eq("abt_mem_accept", ram_addr, 32'h20);
    tick;
    tick;
    check_eq("abt_mem_done",  32'(mem_done), 32'h1);
    check_eq("abt_mem_rdata", mem_rdata, 32'h000000EF);
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check_eq("abt_no_if_done", 32'(n_if_done), 32'(if_done_before));
    check_eq("abt_if_inst",    if_inst, 32'h00100513);

    // Starvation: IF is kept out of each mem_done cycle with if_abort so
    // that every following IDLE cycle is a genuine contention.
    k = 0; mcnt = 0;
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20;
    for (int c = 0; c < 200 && k < 6; c++) begin
      tick;
      if_abort = 1'b0;
      if (mem_done) begin
        seq[k] = 1; k++; mcnt++;
        if (mcnt == 5) mem_req = 1'b0;
        if (if_req) if_abort = 1'b1;
      end
      if (if_done && k < 6) begin
        seq[k] = 2; k++;
        if_req = 1'b0;
      end
    end
    if_abort = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    tick;
    check_eq("stv_count", 32'(k), 32'd6);
    if (k == 6) begin
      check_eq("stv_g0", 32'(seq[0]), 32'd1);
      check_eq("stv_g1", 32'(seq[1]), 32'd1);
      check_eq("stv_g2", 32'(seq[2]), 32'd1);
      check_eq("stv_g3", 32'(seq[3]), 32'd1);
      check_eq("stv_g4", 32'(seq[4]), 32'd2);
      check_eq("stv_g5", 32'(seq[5]), 32'd1);
    end

    // Reset during 3rd byte of a word store
    done_before = n_mem_done;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h80; mem_wdata = 32'hCAFEF00D;
    tick;
    tick;
    tick;
    check_eq("rstw_e2_addr", ram_addr, 32'h82);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    tick;
    check_eq("rstw_ram_we",    32'(ram_we), 32'h0);
    check_eq("rstw_ram_addr",  ram_addr, 32'h0);
    check_eq("rstw_ram_wdata", 32'(ram_wdata), 32'h0);
    check_eq("rstw_mem_done",  32'(mem_done), 32'h0);
    check_eq("rstw_mem_rdata", mem_rdata, 32'h0);
    check_eq("rstw_if_inst",   if_inst, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check_eq("rstw_no_done", 32'(n_mem_done), 32'(done_before));
    check_eq("rstw_ram81", 32'(ram[10'h081]), 32'hF0);
    check_eq("rstw_ram83", 32'(ram[10'h083]), 32'h00);
    do_load("rstw_idle_load", 32'h20, 2'b00, 32'h000000EF, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
